// File: rtl/spi_flash_master.sv
// Byte-wide SPI master for the flash path: one byte out MSB-first per wr_req/wr_ack handshake,
// one byte captured from MISO at the same time; nCS is a registered copy of the sequencer's CS_reg.
module spi_flash_master #(
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       CS_reg,
  input  logic       wr_req,
  input  logic [7:0] send_data,
  output logic       wr_ack,
  output logic [7:0] data_recv,
  output logic       nCS,
  output logic       DCLK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ACK, GAP} state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_shift;

  logic       last_cnt;
  logic       leading;
  logic       sample_now;
  logic       shift_now;
  logic [7:0] rx_next;

  // edge_cnt holds the number of edges already produced, so an even count means
  // the edge about to happen is a leading one.
  assign last_cnt   = (clk_cnt == CW'(CLK_DIV - 1));
  assign leading    = ~edge_cnt[0];
  assign sample_now = leading ^ CPHA;
  assign shift_now  = CPHA ? leading : (~leading && (edge_cnt != 4'd15));
  assign rx_next    = {rx_shift[6:0], MISO};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      edge_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      wr_ack    <= 1'b0;
      data_recv <= '0;
      nCS       <= 1'b1;
      DCLK      <= CPOL;
      MOSI      <= 1'b0;
    end else begin
      nCS    <= CS_reg;
      wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) state <= LOAD;
        end
        LOAD: begin
          tx_shift <= send_data;
          edge_cnt <= '0;
          clk_cnt  <= '0;
          if (!CPHA) MOSI <= send_data[7];
          state <= SHIFT;
        end
        SHIFT: begin
          if (last_cnt) begin
            clk_cnt  <= '0;
            DCLK     <= ~DCLK;
            edge_cnt <= edge_cnt + 4'd1;
            if (sample_now) rx_shift <= rx_next;
            if (shift_now) begin
              MOSI     <= CPHA ? tx_shift[7] : tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
            // The 16th edge may also be the last sample edge, so take the
            // freshly shifted value rather than the stale register.
            if (edge_cnt == 4'd15) begin
              wr_ack    <= 1'b1;
              data_recv <= sample_now ? rx_next : rx_shift;
              state     <= ACK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        ACK: state <= GAP;
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_master.sv
// Drives a mode-0 (CLK_DIV=4) and a mode-3 (CLK_DIV=2) master against a behavioural flash model
// that samples MOSI on DCLK rises and advances MISO on DCLK falls.
module tb_spi_flash_master;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [1:0] cs_reg, wr_req, wr_ack, ncs, dclk, mosi;
  logic [1:0] miso = 2'b00;
  logic [7:0] send_data [2];
  logic [7:0] data_recv [2];

  localparam logic [1:0] CPOL_V = 2'b10;
  localparam logic [1:0] CPHA_V = 2'b10;

  always #5 sys_clk = ~sys_clk;

  spi_flash_master #(.CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .CS_reg(cs_reg[0]), .wr_req(wr_req[0]),
    .send_data(send_data[0]), .wr_ack(wr_ack[0]), .data_recv(data_recv[0]),
    .nCS(ncs[0]), .DCLK(dclk[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_flash_master #(.CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
    .sys_clk(sys_clk), .rst_n(rst_n), .CS_reg(cs_reg[1]), .wr_req(wr_req[1]),
    .send_data(send_data[1]), .wr_ack(wr_ack[1]), .data_recv(data_recv[1]),
    .nCS(ncs[1]), .DCLK(dclk[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  function automatic int cd_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash model: re-armed per byte by toggling arm[i] with the response in resp[i].
  logic [7:0] resp [2];
  logic [1:0] arm = 2'b00;
  logic [1:0] arm_q = 2'b00;
  logic [1:0] dclk_q = CPOL_V;
  logic [7:0] cap [2];
  int         kf [2];

  always @(dclk or arm) begin
    for (int g = 0; g < 2; g++) begin
      if (arm[g] != arm_q[g]) begin
        arm_q[g] = arm[g];
        cap[g]   = 8'h00;
        kf[g]    = 0;
        if (!CPHA_V[g]) miso[g] = resp[g][7];
      end else if (dclk[g] !== dclk_q[g]) begin
        if (dclk[g] === 1'b1) begin
          cap[g] = {cap[g][6:0], mosi[g]};
        end else begin
          if (CPHA_V[g]) begin
            if (kf[g] < 8) miso[g] = resp[g][7 - kf[g]];
          end else if (kf[g] < 7) begin
            miso[g] = resp[g][6 - kf[g]];
          end
          kf[g]++;
        end
      end
    end
    dclk_q = dclk;
  end

  int ack_cnt [2] = '{0, 0};
  always @(negedge sys_clk) begin
    for (int g = 0; g < 2; g++) if (wr_ack[g] === 1'b1) ack_cnt[g]++;
  end

  logic [7:0] tx_q [$];
  logic [7:0] rs_q [$];

  // Streams tx_q out of instance i with wr_req held high, then drops it one
  // cycle after the GAP cycle. Entered and left on a falling clock edge.
  task automatic run_stream(input int i, input bit chg);
    int a0;
    int cnt;
    int n;
    int cd;
    bit got;
    n  = tx_q.size();
    cd = cd_of(i);
    a0 = ack_cnt[i];
    resp[i] = rs_q[0];
    arm[i] = ~arm[i];
    send_data[i] = tx_q[0];
    wr_req[i] = 1'b1;
    for (int b = 0; b < n; b++) begin
      cnt = (b == 0) ? 0 : 1;
      got = 1'b0;
      while (!got && cnt < 400) begin
        @(negedge sys_clk);
        cnt++;
        if (chg && b == 0 && cnt == 3) send_data[i] = 8'h00;
        if (wr_ack[i] === 1'b1) got = 1'b1;
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
      if (!got) begin
        wr_req[i] = 1'b0;
        return;
      end
      if (b == 0) chk("ack_latency", cnt - 1, 16 * cd + 1);
      else        chk("byte_period", cnt, 16 * cd + 4);
      chk("data_recv", {24'd0, data_recv[i]}, {24'd0, rs_q[b]});
      chk("flash_saw", {24'd0, cap[i]}, {24'd0, tx_q[b]});
      chk("ncs_held", {31'd0, ncs[i]}, {31'd0, cs_reg[i]});
      if (b + 1 < n) begin
        resp[i] = rs_q[b + 1];
        arm[i] = ~arm[i];
        send_data[i] = tx_q[b + 1];
      end
      @(negedge sys_clk);
      chk("ack_pulse", {31'd0, wr_ack[i]}, 32'd0);
      chk("dclk_idle", {31'd0, dclk[i]}, {31'd0, CPOL_V[i]});
      if (b + 1 == n) begin
        @(negedge sys_clk);
        wr_req[i] = 1'b0;
      end
    end
    repeat (16 * cd + 12) @(negedge sys_clk);
    chk("ack_count", ack_cnt[i] - a0, n);
  endtask

  initial begin
    int i;
    int n;
    int a0;
    logic [7:0] v;
    logic [11:0] pat;

    rst_n = 1'b0;
    cs_reg = 2'b11;
    wr_req = 2'b00;
    send_data[0] = 8'h00;
    send_data[1] = 8'h00;
    resp[0] = 8'h00;
    resp[1] = 8'h00;

    repeat (3) @(negedge sys_clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_wr_ack", {31'd0, wr_ack[g]}, 32'd0);
      chk("rst_data_recv", {24'd0, data_recv[g]}, 32'd0);
      chk("rst_ncs", {31'd0, ncs[g]}, 32'd1);
      chk("rst_dclk", {31'd0, dclk[g]}, {31'd0, CPOL_V[g]});
      chk("rst_mosi", {31'd0, mosi[g]}, 32'd0);
    end
    rst_n = 1'b1;
    cs_reg = 2'b00;
    repeat (2) @(negedge sys_clk);

    // Mode 0 and mode 3 directed bytes.
    tx_q = '{8'hA5}; rs_q = '{8'h3C}; run_stream(0, 1'b0);
    tx_q = '{8'h9F}; rs_q = '{8'hEF}; run_stream(1, 1'b0);

    // Sequencer-style four-byte stream.
    tx_q = '{8'h03, 8'h12, 8'h34, 8'h56};
    rs_q = '{8'hC1, 8'h5E, 8'h77, 8'h2B};
    run_stream(0, 1'b0);

    // send_data changes after LOAD: the in-flight byte must be unaffected.
    tx_q = '{8'hFF}; rs_q = '{8'h42}; run_stream(0, 1'b1);

    // Randomised streams on both modes.
    for (int r = 0; r < 6; r++) begin
      i = r % 2;
      n = 1 + int'($urandom_range(2));
      tx_q = {};
      rs_q = {};
      for (int b = 0; b < n; b++) begin
        tx_q.push_back(8'($urandom));
        rs_q.push_back(8'($urandom));
      end
      run_stream(i, 1'b0);
    end

    tx_q = '{8'h24}; rs_q = '{8'h81}; run_stream(0, 1'b0);
    tx_q = '{8'hB6}; rs_q = '{8'h7E}; run_stream(1, 1'b0);

    // Asynchronous reset around the 7th DCLK edge of a byte.
    a0 = ack_cnt[0];
    resp[0] = 8'h99;
    arm[0] = ~arm[0];
    send_data[0] = 8'h3E;
    wr_req[0] = 1'b1;
    repeat (30) @(posedge sys_clk);
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("arst_ncs", {31'd0, ncs[g]}, 32'd1);
      chk("arst_dclk", {31'd0, dclk[g]}, {31'd0, CPOL_V[g]});
      chk("arst_wr_ack", {31'd0, wr_ack[g]}, 32'd0);
      chk("arst_data_recv", {24'd0, data_recv[g]}, 32'd0);
    end
    wr_req[0] = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    chk("no_ack_after_arst", ack_cnt[0] - a0, 0);
    v = 8'($urandom);
    tx_q = '{8'h5A}; rs_q = '{v}; run_stream(0, 1'b0);

    // CS_reg toggling with no transfer requested.
    a0 = ack_cnt[0] + ack_cnt[1];
    pat = {9'($urandom), 3'b101};
    for (int k = 0; k < 12; k++) begin
      cs_reg = {2{pat[k]}};
      @(negedge sys_clk);
      chk("ncs_follow0", {31'd0, ncs[0]}, {31'd0, pat[k]});
      chk("ncs_follow1", {31'd0, ncs[1]}, {31'd0, pat[k]});
      chk("cs_dclk_idle", {30'd0, dclk}, {30'd0, CPOL_V});
    end
    repeat (20) @(negedge sys_clk);
    chk("cs_no_ack", ack_cnt[0] + ack_cnt[1] - a0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- Byte-level SPI master engine directly downstream of the flash command sequencer.
- Accepts one byte per wr_req/wr_ack handshake and shifts it out MSB-first on MOSI.
- Simultaneously captures one byte from MISO and returns it on data_recv.
- Registers the sequencer's chip-select request onto the flash nCS pin. Drives the physical SPI flash pins.

Parameters:
- CLK_DIV, 4: sys_clk cycles per DCLK half-period; must be ≥1; DCLK = sys_clk/(2*CLK_DIV).
- CPOL, 0: DCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- CS_reg  in  1  chip-select request from sequencer (1 = deselect)
- wr_req  in  1  byte transfer request, level, held until wr_ack
- send_data  in  8  byte to transmit, stable while wr_req=1
- wr_ack  out  1  one-cycle pulse: byte done, data_recv valid
- data_recv  out  8  byte received in the last transfer, held until the next wr_ack
- nCS  out  1  flash chip select, active low
- DCLK  out  1  SPI serial clock
- MOSI  out  1  serial data to flash
- MISO  in  1  serial data from flash

Behaviour:
- Reset values: wr_ack=0, data_recv=0, nCS=1, DCLK=CPOL, MOSI=0, state=IDLE, all counters 0.
- nCS <= CS_reg every cycle (1-cycle latency), independent of the FSM.
- States:
  - IDLE: if wr_req=1, go to LOAD.
  - LOAD (1 cycle): tx_shift<=send_data; edge_cnt<=0; clk_cnt<=0. If CPHA=0, MOSI<=send_data[7]. Go to SHIFT.
  - SHIFT: clk_cnt counts 0..CLK_DIV-1. On clk_cnt=CLK_DIV-1: toggle DCLK, increment edge_cnt (0..15), clk_cnt<=0.
    - Odd edge number (1st, 3rd, …, counting from 1) = leading edge; even = trailing edge.
    - Sample edge: rx_shift<={rx_shift[6:0],MISO}.
    - Shift edge: drive the next tx bit on MOSI. CPHA=0: shift only on trailing edges 2..14; no MOSI change on the 16th edge. CPHA=1: shift on every leading edge, bit7 first.
    - After the 16th edge (DCLK back at CPOL), go to ACK.
  - ACK (1 cycle): wr_ack=1; data_recv<=rx_shift. Go to GAP.
  - GAP (1 cycle): wr_req ignored. This absorbs the sequencer's registered wr_req lag. Go to IDLE.
- Latency: wr_ack asserts exactly 16*CLK_DIV+1 cycles after the LOAD cycle. IDLE→LOAD is 1 cycle. Back-to-back byte period = 16*CLK_DIV+4 cycles.
- MOSI holds its last value between bytes.
- DCLK only toggles in SHIFT; it never glitches in IDLE/ACK/GAP.
- Handshake rules: send_data is captured only in LOAD, so changes after LOAD do not affect the byte in flight. wr_req dropping mid-byte does not abort; the byte completes and wr_ack still pulses.
- CS_reg rising mid-byte: nCS follows after 1 cycle. The transfer still completes and acks; this is the sequencer's responsibility and is not aborted.
- wr_req=1 seen in GAP: ignored. If still 1 in IDLE, a new LOAD occurs.
- Async reset mid-byte: immediate return to reset values; no wr_ack is generated. The flash is deselected because nCS=1.
- CLK_DIV=1: DCLK toggles every cycle; the same 16-edge rule applies.

Test Plan:
- Mode 0, CLK_DIV=4, send_data=0xA5, MISO model returns 0x3C: MOSI sampled on DCLK rises = 1,0,1,0,0,1,0,1; data_recv=0x3C; wr_ack is a 1-cycle pulse 65 cycles after LOAD; DCLK idles 0.
- Mode 3 (CPOL=1, CPHA=1), CLK_DIV=2, send=0x9F, MISO=0xEF: DCLK idles 1; flash samples on rising edges see 0x9F; data_recv=0xEF; wr_ack 33 cycles after LOAD.
- Sequencer-style stream: CS_reg=0, four bytes 0x03,0x12,0x34,0x56 with wr_req re-registered 1 cycle after each ack: exactly 4 acks; no extra byte from a stale wr_req; nCS low throughout; byte period 68 cycles at CLK_DIV=4.
- send_data changed from 0xFF to 0x00 two cycles after LOAD: transmitted byte is 0xFF.
- rst_n pulsed low at edge 7 of a byte: nCS=1, DCLK=CPOL, wr_ack=0, data_recv=0 immediately. After release, a new wr_req transfers 0x5A correctly.
- CS_reg toggles 1→0→1 with wr_req=0: nCS mirrors with 1-cycle delay; DCLK stays at CPOL; no wr_ack.
